// File: rtl/regfile_mp_if.sv
// ----------------------------------------------------------------------------
// regfile_mp_if
// Bundle of all non-clock signals of the multi-port register file.
//   master : decode / writeback side (drives addresses, writes, claim, flush)
//   slave  : the register file itself
// Signals (flat packing, port p at [p*W +: W]):
//   rd_addr/rd_data/rd_ready  : combinational read ports
//   wr_en/wr_addr/wr_data     : write ports (higher index wins on conflict)
//   claim_en/claim_addr       : mark a destination register pending
//   flush                     : clear every pending bit
//   busy_count                : number of pending registers
// ----------------------------------------------------------------------------
interface regfile_mp_if #(
    parameter int ADDRESS_WIDTH = 5,
    parameter int DATA_WIDTH    = 32,
    parameter int READ_PORTS    = 2,
    parameter int WRITE_PORTS   = 2
);
    localparam int DEPTH = 2 ** ADDRESS_WIDTH;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [READ_PORTS*ADDRESS_WIDTH-1:0]  rd_addr;
    logic [READ_PORTS*DATA_WIDTH-1:0]     rd_data;
    logic [READ_PORTS-1:0]                rd_ready;
    logic [WRITE_PORTS-1:0]               wr_en;
    logic [WRITE_PORTS*ADDRESS_WIDTH-1:0] wr_addr;
    logic [WRITE_PORTS*DATA_WIDTH-1:0]    wr_data;
    logic                                 claim_en;
    logic [ADDRESS_WIDTH-1:0]             claim_addr;
    logic                                 flush;
    logic [CNT_W-1:0]                     busy_count;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, claim_en, claim_addr, flush,
        input  rd_data, rd_ready, busy_count
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, claim_en, claim_addr, flush,
        output rd_data, rd_ready, busy_count
    );
endinterface

// File: rtl/regfile_mp.sv
// ----------------------------------------------------------------------------
// regfile_mp
// Multi-port integer register file with write-through bypass, optional
// hardwired-zero register 0 and a per-register pending scoreboard.
// Ports:
//   clk  : clock, all state on rising edge
//   rst  : asynchronous active-high reset (data, pending, busy count -> 0)
//   bus  : regfile_mp_if.slave (read/write ports, claim, flush, busy_count)
// ----------------------------------------------------------------------------

// One combinational read port: zero-register override, then bypass from the
// current write ports, then the stored value with scoreboard-based ready.
module regfile_mp_rdport #(
    parameter int ADDRESS_WIDTH = 5,
    parameter int DATA_WIDTH    = 32,
    parameter int WRITE_PORTS   = 2,
    parameter int ZERO_REG      = 1,
    parameter int BYPASS        = 1
) (
    input  logic [ADDRESS_WIDTH-1:0]                  addr_i,
    input  logic [DATA_WIDTH-1:0]                     arr_data_i,
    input  logic                                      pend_i,
    input  logic [WRITE_PORTS-1:0]                    wr_ok_i,
    input  logic [WRITE_PORTS-1:0][ADDRESS_WIDTH-1:0] wr_addr_i,
    input  logic [WRITE_PORTS-1:0][DATA_WIDTH-1:0]    wr_data_i,
    output logic [DATA_WIDTH-1:0]                     data_o,
    output logic                                      ready_o
);
    logic                  hit;
    logic [DATA_WIDTH-1:0] byp_data;

    always_comb begin
        hit      = 1'b0;
        byp_data = '0;
        // Ascending scan so the highest-index matching port is the one kept.
        for (int w = 0; w < WRITE_PORTS; w++) begin
            if (BYPASS != 0 && wr_ok_i[w] && wr_addr_i[w] == addr_i) begin
                hit      = 1'b1;
                byp_data = wr_data_i[w];
            end
        end

        if (ZERO_REG != 0 && addr_i == '0) begin
            data_o  = '0;
            ready_o = 1'b1;
        end else if (hit) begin
            data_o  = byp_data;
            ready_o = 1'b1;
        end else begin
            data_o  = arr_data_i;
            ready_o = !pend_i;
        end
    end
endmodule

module regfile_mp #(
    parameter int ADDRESS_WIDTH = 5,
    parameter int DATA_WIDTH    = 32,
    parameter int READ_PORTS    = 2,
    parameter int WRITE_PORTS   = 2,
    parameter int ZERO_REG      = 1,
    parameter int BYPASS        = 1
) (
    input  logic          clk,
    input  logic          rst,
    regfile_mp_if.slave   bus
);
    localparam int DEPTH = 2 ** ADDRESS_WIDTH;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0][DATA_WIDTH-1:0] mem_q, mem_d;
    logic [DEPTH-1:0]                 pend_q, pend_d;
    logic [CNT_W-1:0]                 busy_q, busy_d;

    logic [WRITE_PORTS-1:0][ADDRESS_WIDTH-1:0] wr_addr_w;
    logic [WRITE_PORTS-1:0][DATA_WIDTH-1:0]    wr_data_w;
    logic [READ_PORTS-1:0][ADDRESS_WIDTH-1:0]  rd_addr_w;
    logic [READ_PORTS-1:0][DATA_WIDTH-1:0]     rd_data_w;
    logic [READ_PORTS-1:0]                     rd_ready_w;
    logic [WRITE_PORTS-1:0]                    wr_ok;
    logic                                      claim_ok;

    assign wr_addr_w = bus.wr_addr;
    assign wr_data_w = bus.wr_data;
    assign rd_addr_w = bus.rd_addr;

    // Writes and claims aimed at a hardwired zero register are dropped here,
    // so neither the array, the scoreboard nor the bypass ever sees them.
    always_comb begin
        for (int w = 0; w < WRITE_PORTS; w++) begin
            wr_ok[w] = bus.wr_en[w] && !(ZERO_REG != 0 && wr_addr_w[w] == '0);
        end
        claim_ok = bus.claim_en && !(ZERO_REG != 0 && bus.claim_addr == '0);
    end

    always_comb begin
        mem_d  = mem_q;
        pend_d = pend_q;
        // Later ports overwrite earlier ones: highest index wins.
        for (int w = 0; w < WRITE_PORTS; w++) begin
            if (wr_ok[w]) begin
                mem_d[wr_addr_w[w]]  = wr_data_w[w];
                pend_d[wr_addr_w[w]] = 1'b0;
            end
        end
        // Claim after release: a new producer supersedes the returning one.
        if (claim_ok) begin
            pend_d[bus.claim_addr] = 1'b1;
        end
        if (bus.flush) begin
            pend_d = '0;
        end
        // Full recount keeps busy_count equal to popcount by construction.
        busy_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            busy_d = busy_d + CNT_W'(pend_d[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q  <= '0;
            pend_q <= '0;
            busy_q <= '0;
        end else begin
            mem_q  <= mem_d;
            pend_q <= pend_d;
            busy_q <= busy_d;
        end
    end

    for (genvar p = 0; p < READ_PORTS; p++) begin : g_rd
        regfile_mp_rdport #(
            .ADDRESS_WIDTH (ADDRESS_WIDTH),
            .DATA_WIDTH    (DATA_WIDTH),
            .WRITE_PORTS   (WRITE_PORTS),
            .ZERO_REG      (ZERO_REG),
            .BYPASS        (BYPASS)
        ) u_rd (
            .addr_i     (rd_addr_w[p]),
            .arr_data_i (mem_q[rd_addr_w[p]]),
            .pend_i     (pend_q[rd_addr_w[p]]),
            .wr_ok_i    (wr_ok),
            .wr_addr_i  (wr_addr_w),
            .wr_data_i  (wr_data_w),
            .data_o     (rd_data_w[p]),
            .ready_o    (rd_ready_w[p])
        );
    end

    assign bus.rd_data    = rd_data_w;
    assign bus.rd_ready   = rd_ready_w;
    assign bus.busy_count = busy_q;
endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;
    localparam int AW    = 5;
    localparam int DW    = 32;
    localparam int RP    = 2;
    localparam int WP    = 2;
    localparam int DEPTH = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    regfile_mp_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .READ_PORTS(RP), .WRITE_PORTS(WP)) bus ();

    regfile_mp #(
        .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .READ_PORTS(RP),
        .WRITE_PORTS(WP), .ZERO_REG(1), .BYPASS(1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Stimulus for the current cycle; the model reads the same values.
    bit          wen   [WP];
    int          waddr [WP];
    logic [31:0] wdata [WP];
    int          raddr [RP];
    bit          claim;
    int          caddr;
    bit          flsh;

    // Architectural state of the reference model.
    logic [31:0] mdl_mem  [DEPTH];
    bit          mdl_pend [DEPTH];

    int passed = 0;
    int total  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic mdl_reset();
        for (int i = 0; i < DEPTH; i++) begin
            mdl_mem[i]  = '0;
            mdl_pend[i] = 1'b0;
        end
    endtask

    function automatic int mdl_busy();
        int n = 0;
        for (int i = 0; i < DEPTH; i++) n += int'(mdl_pend[i]);
        return n;
    endfunction

    // Expected read: register 0 is constant zero; otherwise the last enabled
    // write to the address this cycle is forwarded; else stored value.
    task automatic mdl_read(input int a, output logic [31:0] d, output logic r);
        d = mdl_mem[a];
        r = !mdl_pend[a];
        for (int w = 0; w < WP; w++)
            if (wen[w] && waddr[w] == a) begin
                d = wdata[w];
                r = 1'b1;
            end
        if (a == 0) begin
            d = '0;
            r = 1'b1;
        end
    endtask

    task automatic mdl_edge();
        for (int w = 0; w < WP; w++)
            if (wen[w] && waddr[w] != 0) begin
                mdl_mem[waddr[w]]  = wdata[w];
                mdl_pend[waddr[w]] = 1'b0;
            end
        if (claim && caddr != 0) mdl_pend[caddr] = 1'b1;
        if (flsh) for (int i = 0; i < DEPTH; i++) mdl_pend[i] = 1'b0;
    endtask

    task automatic idle();
        for (int w = 0; w < WP; w++) begin
            wen[w] = 0; waddr[w] = 0; wdata[w] = '0;
        end
        claim = 0; caddr = 0; flsh = 0;
    endtask

    task automatic apply();
        for (int w = 0; w < WP; w++) begin
            bus.wr_en[w]            = wen[w];
            bus.wr_addr[w*AW +: AW] = AW'(waddr[w]);
            bus.wr_data[w*DW +: DW] = wdata[w];
        end
        for (int p = 0; p < RP; p++) bus.rd_addr[p*AW +: AW] = AW'(raddr[p]);
        bus.claim_en   = claim;
        bus.claim_addr = AW'(caddr);
        bus.flush      = flsh;
    endtask

    task automatic check_reads(input string tag);
        logic [31:0] d;
        logic        r;
        for (int p = 0; p < RP; p++) begin
            mdl_read(raddr[p], d, r);
            chk({tag, "_data"},  bus.rd_data[p*DW +: DW], d);
            chk({tag, "_ready"}, 32'(bus.rd_ready[p]), 32'(r));
        end
    endtask

    task automatic tick(input string tag);
        apply();
        #1 check_reads(tag);
        @(posedge clk);
        mdl_edge();
        #1 chk({tag, "_busy"}, 32'(bus.busy_count), 32'(mdl_busy()));
    endtask

    initial begin
        mdl_reset();
        idle();
        raddr[0] = 5; raddr[1] = 0;
        apply();
        #12;
        check_reads("rst_init");
        chk("rst_init_busy", 32'(bus.busy_count), 32'd0);
        rst = 1'b0;

        // Write x5, then reset asynchronously mid-cycle.
        wen[0] = 1; waddr[0] = 5; wdata[0] = 32'hDEADBEEF;
        tick("wr_x5");
        idle();
        apply();
        #1 check_reads("x5_held");
        chk("x5_val", bus.rd_data[0 +: DW], 32'hDEADBEEF);
        rst = 1'b1;
        #1;
        mdl_reset();
        check_reads("rst_mid");
        chk("rst_mid_busy", 32'(bus.busy_count), 32'd0);
        // Write issued while reset is held must be lost.
        wen[0] = 1; waddr[0] = 5; wdata[0] = 32'h77;
        apply();
        @(posedge clk);
        #1 idle();
        apply();
        #1 check_reads("rst_lost");
        chk("rst_lost_x5", bus.rd_data[0 +: DW], 32'h0);
        rst = 1'b0;

        // Dual write conflict on x3.
        raddr[0] = 3; raddr[1] = 3;
        wen[0] = 1; waddr[0] = 3; wdata[0] = 32'h11;
        wen[1] = 1; waddr[1] = 3; wdata[1] = 32'h22;
        apply();
        #1 chk("conflict_bypass", bus.rd_data[0 +: DW], 32'h22);
        tick("conflict");
        idle();
        apply();
        #1 chk("conflict_array", bus.rd_data[DW +: DW], 32'h22);
        tick("conflict_after");

        // Zero register: write and claim x0.
        raddr[0] = 0; raddr[1] = 0;
        wen[0] = 1; waddr[0] = 0; wdata[0] = 32'hFFFFFFFF;
        claim = 1; caddr = 0;
        tick("x0_wr");
        idle();
        tick("x0_after");
        chk("x0_busy", 32'(bus.busy_count), 32'd0);

        // Scoreboard round trip on x7.
        raddr[0] = 7; raddr[1] = 3;
        claim = 1; caddr = 7;
        tick("claim7");
        chk("claim7_busy", 32'(bus.busy_count), 32'd1);
        idle();
        apply();
        #1 chk("x7_notready", 32'(bus.rd_ready[0]), 32'd0);
        wen[1] = 1; waddr[1] = 7; wdata[1] = 32'h1234;
        apply();
        #1 chk("x7_byp_ready", 32'(bus.rd_ready[0]), 32'd1);
        chk("x7_byp_data", bus.rd_data[0 +: DW], 32'h1234);
        tick("release7");
        chk("release7_busy", 32'(bus.busy_count), 32'd0);

        // Claim and write x9 in the same cycle: claim wins.
        idle();
        raddr[0] = 9;
        claim = 1; caddr = 9;
        wen[0] = 1; waddr[0] = 9; wdata[0] = 32'hA5A5;
        tick("cw9");
        idle();
        apply();
        #1 chk("cw9_ready", 32'(bus.rd_ready[0]), 32'd0);
        chk("cw9_data", bus.rd_data[0 +: DW], 32'hA5A5);
        chk("cw9_busy", 32'(bus.busy_count), 32'd1);

        // Claims on x1, x2, x4, then flush alongside a claim of x6.
        claim = 1; caddr = 1; tick("cl1");
        caddr = 2; tick("cl2");
        caddr = 4; tick("cl4");
        chk("pre_flush_busy", 32'(bus.busy_count), 32'd4);
        caddr = 6; flsh = 1;
        raddr[0] = 6; raddr[1] = 4;
        tick("flush");
        chk("flush_busy", 32'(bus.busy_count), 32'd0);
        idle();
        raddr[0] = 9; raddr[1] = 3;
        tick("post_flush");

        // Randomized traffic on a narrow address range to force collisions.
        for (int n = 0; n < 300; n++) begin
            for (int w = 0; w < WP; w++) begin
                wen[w]   = $urandom_range(0, 1) == 1;
                waddr[w] = $urandom_range(0, 7);
                wdata[w] = $urandom;
            end
            for (int p = 0; p < RP; p++) raddr[p] = $urandom_range(0, 7);
            claim = $urandom_range(0, 1) == 1;
            caddr = $urandom_range(0, 7);
            flsh  = $urandom_range(0, 15) == 0;
            tick("rand");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
